aes_spi_master: RTL and testbench

Host-side SPI master that feeds the AES SPI slave core. It accepts a 128-bit data block and a 256-bit key field on a parallel start/busy/done handshake, and serialises them MSB-first onto MOSI under chip-select. It then clocks a configurable turnaround gap and shifts the 128-bit encrypted or decrypted result back in from MISO. It sits between the system controller and the off-block SPI link to the AES slave.

---
 rtl/aes_spi_master.sv | 141 ++++++++++++++
 tb/tb_aes_spi_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_master.sv
// aes_spi_master: SPI mode-0 master that streams {data, key} to the AES SPI
// slave, waits a turnaround gap, then clocks the 128-bit result back in.
module aes_spi_master #(
  parameter int CLK_DIV     = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] result,
  output logic         sclk,
  output logic         cs_n,
  output logic         mosi,
  input  logic         miso
);

  typedef enum logic [2:0] {
    IDLE,
    TX,
    TURN,
    RX,
    HOLD
  } state_t;

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [8:0] TX_LAST   = 9'd383;
  localparam logic [8:0] RX_LAST   = 9'd127;
  localparam logic [8:0] TURN_LAST = 9'(TURN_CYCLES - 1);

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [8:0]    bit_cnt;
  // Bit 127 of data_in goes straight into mosi on accept, so the shift
  // register only has to hold the remaining 383 bits.
  logic [382:0]  tx_sr;
  logic [127:0]  rx_sr;
  logic          wrap;
  logic          rise;
  logic          fall;

  assign wrap = (half_cnt == HALF_LAST);
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  // Frame sequencer: half-period timing, serialisation, capture and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr    <= {data_in[126:0], key_in};
            mosi     <= data_in[127];
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            sclk     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX;
          end
        end

        TX, TURN, RX: begin
          half_cnt <= wrap ? '0 : half_cnt + 1'b1;
          if (wrap) begin
            sclk <= ~sclk;
          end
          if (rise && state == RX) begin
            rx_sr <= {rx_sr[126:0], miso};
          end
          if (fall) begin
            case (state)
              TX: begin
                tx_sr <= {tx_sr[381:0], 1'b0};
                if (bit_cnt == TX_LAST) begin
                  bit_cnt <= '0;
                  mosi    <= 1'b0;
                  state   <= (TURN_CYCLES == 0) ? RX : TURN;
                end else begin
                  bit_cnt <= bit_cnt + 9'd1;
                  mosi    <= tx_sr[382];
                end
              end
              TURN: begin
                if (bit_cnt == TURN_LAST) begin
                  bit_cnt <= '0;
                  state   <= RX;
                end else begin
                  bit_cnt <= bit_cnt + 9'd1;
                end
              end
              default: begin
                if (bit_cnt == RX_LAST) begin
                  bit_cnt <= '0;
                  state   <= HOLD;
                end else begin
                  bit_cnt <= bit_cnt + 9'd1;
                end
              end
            endcase
          end
        end

        HOLD: begin
          if (wrap) begin
            half_cnt <= '0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= rx_sr;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_master.sv
// tb_aes_spi_master: directed bench with a behavioural SPI slave for two
// parameterisations of the master (defaults, and CLK_DIV=1/TURN_CYCLES=0).
module tb_aes_spi_master;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] data_in;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic [127:0] result;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;

  logic         start1;
  logic         busy1;
  logic         done1;
  logic [127:0] result1;
  logic         sclk1;
  logic         cs_n1;
  logic         mosi1;
  logic         miso1;

  int n_checks;
  int n_fail;
  int cyc;

  logic [127:0] rx_pat;

  int           rise_cnt;
  logic [513:0] cap;
  int           cs_low_total;
  int           done_total;
  logic         last_sclk;
  logic         last_cs;

  int   rise_cnt1;
  int   first_rise_cyc1;
  logic last_sclk1;
  logic last_cs1;

  localparam logic [127:0] DATA1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY1  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PAT1  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] DATA2 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [255:0] KEY2  =
    256'h00000000000000000000000000000000a5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
  localparam logic [127:0] PAT4  = 128'h0123456789abcdeffedcba9876543210;

  aes_spi_master #(.CLK_DIV(2), .TURN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .key_in(key_in),
    .busy(busy), .done(done), .result(result), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso)
  );

  aes_spi_master #(.CLK_DIV(1), .TURN_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in), .key_in(key_in),
    .busy(busy1), .done(done1), .result(result1), .sclk(sclk1), .cs_n(cs_n1),
    .mosi(mosi1), .miso(miso1)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter advanced on every active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Slave model for the default instance: captures mosi on sclk rise and
  // drives the RX pattern on sclk fall, ahead of the next rise.
  always @(negedge clk) begin
    if (last_cs && !cs_n) begin
      rise_cnt = 0;
      cap      = '0;
    end
    if (!cs_n) cs_low_total = cs_low_total + 1;
    if (done) done_total = done_total + 1;
    if (sclk && !last_sclk) begin
      cap      = {cap[512:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
    if (!sclk && last_sclk && rise_cnt >= 386 && rise_cnt < 514) begin
      miso = rx_pat[513 - rise_cnt];
    end
    last_sclk = sclk;
    last_cs   = cs_n;
  end

  // Slave model for the fast instance (no turnaround gap).
  always @(negedge clk) begin
    if (last_cs1 && !cs_n1) rise_cnt1 = 0;
    if (sclk1 && !last_sclk1) begin
      if (rise_cnt1 == 0) first_rise_cyc1 = cyc;
      rise_cnt1 = rise_cnt1 + 1;
    end
    if (!sclk1 && last_sclk1 && rise_cnt1 >= 384 && rise_cnt1 < 512) begin
      miso1 = rx_pat[511 - rise_cnt1];
    end
    last_sclk1 = sclk1;
    last_cs1   = cs_n1;
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [383:0] obs,
                              input logic [383:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame on the default instance and checks the whole transfer.
  task automatic apply_stimulus(input logic [127:0] d, input logic [255:0] k,
                                input logic [127:0] pat, input bit pulse_mid,
                                input bit hold_start, input logic [127:0] prev_res);
    int c0;
    int d0;
    int acc;
    bit seen;
    rx_pat = pat;
    c0 = cs_low_total;
    d0 = done_total;
    data_in = d;
    key_in  = k;
    start   = 1'b1;
    @(negedge clk); #1;
    if (!hold_start) start = 1'b0;
    acc = cyc;
    check_output("accept_cs_n", cs_n, 0);
    check_output("accept_busy", busy, 1);
    check_output("accept_sclk", sclk, 0);
    check_output("accept_mosi", mosi, d[127]);
    data_in = '0;
    key_in  = '0;
    seen = 0;
    for (int i = 1; i <= 2200; i++) begin
      @(negedge clk); #1;
      if (pulse_mid && i == 500) begin
        check_output("mid_busy", busy, 1);
        start = 1'b1;
      end
      if (pulse_mid && i == 501) start = 1'b0;
      if (i == 1000) check_output("result_held", result, prev_res);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check_output("done_seen", seen, 1);
    check_output("latency", cyc - acc, 2058);
    check_output("cs_low_width", cs_low_total - c0, 2058);
    check_output("done_count", done_total - d0, 1);
    check_output("sclk_rises", rise_cnt, 514);
    check_output("tx_bits", cap[513:130], {d, k});
    check_output("turn_bits", cap[129:128], 0);
    check_output("result", result, pat);
    check_output("done_busy", busy, 0);
    check_output("done_cs_n", cs_n, 1);
    @(negedge clk); #1;
    check_output("done_width", done, 0);
    if (hold_start) begin
      check_output("relaunch_cs_n", cs_n, 0);
      check_output("relaunch_busy", busy, 1);
    end
  endtask

  initial begin
    int idle_bad;
    int c0;
    int d0;
    int acc;
    bit seen;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    rise_cnt = 0;
    cap = '0;
    cs_low_total = 0;
    done_total = 0;
    last_sclk = 1'b0;
    last_cs = 1'b1;
    rise_cnt1 = 0;
    first_rise_cyc1 = 0;
    last_sclk1 = 1'b0;
    last_cs1 = 1'b1;
    rx_pat = '0;
    miso = 1'b0;
    miso1 = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    data_in = '0;
    key_in = '0;

    // Reset and idle behaviour.
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || result !== '0) idle_bad = idle_bad + 1;
    end
    check_output("idle_bad_cycles", idle_bad, 0);
    check_output("reset_cs_n", cs_n, 1);
    check_output("reset_result", result, 0);

    // Frame 1 with a start pulse mid-frame that must be ignored.
    apply_stimulus(DATA1, KEY1, PAT1, 1'b1, 1'b0, 128'h0);
    c0 = cs_low_total;
    repeat (30) @(negedge clk);
    #1;
    check_output("no_queued_frame", cs_low_total - c0, 0);

    // Frame 2 with start held high: frame 3 launches right after done.
    apply_stimulus(DATA2, KEY2, ~PAT1, 1'b0, 1'b1, PAT1);
    start = 1'b0;

    // Abort frame 3 at TX bit 100.
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (rise_cnt >= 100) begin
        seen = 1;
        break;
      end
    end
    check_output("abort_reached", seen, 1);
    d0 = done_total;
    rst = 1'b1;
    #1;
    check_output("abort_outputs", {cs_n, sclk, mosi, busy, done}, 5'b10000);
    check_output("abort_result", result, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    c0 = cs_low_total;
    repeat (60) @(negedge clk);
    #1;
    check_output("abort_no_done", done_total - d0, 0);
    check_output("abort_cs_idle", cs_low_total - c0, 0);

    // Frame 4 after the abort runs completely.
    apply_stimulus(DATA1, KEY2, PAT4, 1'b0, 1'b0, 128'h0);

    // Fast instance: CLK_DIV=1, no turnaround.
    rx_pat = PAT1;
    data_in = DATA2;
    key_in = KEY1;
    start1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
    acc = cyc;
    seen = 0;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk); #1;
      if (done1) begin
        seen = 1;
        break;
      end
    end
    check_output("fast_done_seen", seen, 1);
    check_output("fast_latency", cyc - acc, 1025);
    check_output("fast_result", result1, PAT1);
    check_output("fast_sclk_rises", rise_cnt1, 512);
    check_output("fast_first_rise", first_rise_cyc1 - acc, 1);
    check_output("fast_cs_n", cs_n1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
